// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
//   Shared definitions for the seven-segment scan controller:
//   - scan_state_t : scan FSM states (IDLE / SHOW / BLANK)
//   - SEG_OFF      : active-high "all segments dark" pattern
//   - SEG_TABLE    : active-high gfedcba pattern per hex digit 0..F
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/sevenseg_hex_decode.sv
// sevenseg_hex_decode
//   Combinational hex-to-seven-segment decoder, active-high, bit0=a .. bit6=g.
//   Ports:
//     hex  in   4  hex value
//     seg  out  7  active-high segment pattern
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[hex];
    end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//   Time-multiplexed scan controller for a multi-digit seven-segment display.
//   Holds a hex value and decimal point per digit, lights one digit at a time
//   for DWELL_CYCLES, then darkens everything for BLANK_CYCLES to avoid ghosting.
//   Ports:
//     clk         in   1           system clock
//     rst_n       in   1           asynchronous active-low reset
//     enable      in   1           1 = scanning, 0 = display dark
//     wr_en       in   1           single-cycle write strobe
//     wr_addr     in   3           digit index (>= NUM_DIGITS ignored)
//     wr_data     in   4           hex value for the digit
//     wr_dp       in   1           decimal point for the digit
//     blank_mask  in   NUM_DIGITS  bit i = 1 keeps digit i dark for its slot
//     seg         out  7           segments a..g (polarity per SEG_ACTIVE_LOW)
//     dp          out  1           decimal point (polarity per SEG_ACTIVE_LOW)
//     dig_sel     out  NUM_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW)
//     frame_tick  out  1           one-cycle pulse when the scan wraps to digit 0
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DWELL_CYCLES   = 20000,
    parameter int BLANK_CYCLES   = 200,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic                  wr_dp,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_tick
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Polarity is applied only at the pins; everything inside is active-high.
    function automatic logic [6:0] seg_pol(input logic [6:0] s);
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    function automatic logic dp_pol(input logic d);
        return SEG_ACTIVE_LOW ? ~d : d;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] dig_pol(input logic [NUM_DIGITS-1:0] d);
        return DIG_ACTIVE_LOW ? ~d : d;
    endfunction

    // ---------------- register file (write port) ----------------
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dpreg_q;
    logic                  wr_hit;
    logic [IDX_W-1:0]      wr_idx;

    always_comb begin
        wr_hit = wr_en && (int'(wr_addr) < NUM_DIGITS);
        wr_idx = wr_addr[IDX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 4'h0;
            end
            dpreg_q <= '0;
        end else if (wr_hit) begin
            digit_q[wr_idx] <= wr_data;
            dpreg_q[wr_idx] <= wr_dp;
        end
    end

    // ---------------- scan FSM next-state ----------------
    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             tick_d;

    always_comb begin
        idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        tick_d  = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES == 0) begin
                            // No gap: step straight into the next digit's slot.
                            idx_d  = idx_inc;
                            load   = 1'b1;
                            tick_d = (idx_q == IDX_LAST);
                        end else begin
                            state_d = BLANK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        idx_d   = idx_inc;
                        cnt_d   = '0;
                        load    = 1'b1;
                        tick_d  = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Display latch: captured only on SHOW entry, so writes landing during a
    // dwell (or on the entry edge itself) are not seen until the next entry.
    logic [3:0] disp_val_q, disp_val_d;
    logic       disp_dp_q, disp_dp_d;
    logic       disp_mask_q, disp_mask_d;

    always_comb begin
        disp_val_d  = disp_val_q;
        disp_dp_d   = disp_dp_q;
        disp_mask_d = disp_mask_q;
        if (load) begin
            disp_val_d  = digit_q[idx_d];
            disp_dp_d   = dpreg_q[idx_d];
            disp_mask_d = blank_mask[idx_d];
        end
    end

    // ---------------- output decode ----------------
    logic [6:0]            seg_hi_d;
    logic                  lit_d;
    logic [NUM_DIGITS-1:0] sel_hi_d;

    sevenseg_hex_decode u_decode (
        .hex (disp_val_d),
        .seg (seg_hi_d)
    );

    always_comb begin
        lit_d    = (state_d == SHOW) && !disp_mask_d;
        sel_hi_d = '0;
        if (lit_d) begin
            sel_hi_d[idx_d] = 1'b1;
        end
    end

    // ---------------- registered state and pins ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            disp_val_q  <= 4'h0;
            disp_dp_q   <= 1'b0;
            disp_mask_q <= 1'b0;
            seg         <= seg_pol(SEG_OFF);
            dp          <= dp_pol(1'b0);
            dig_sel     <= dig_pol('0);
            frame_tick  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            disp_val_q  <= disp_val_d;
            disp_dp_q   <= disp_dp_d;
            disp_mask_q <= disp_mask_d;
            seg         <= seg_pol(lit_d ? seg_hi_d : SEG_OFF);
            dp          <= dp_pol(lit_d ? disp_dp_d : 1'b0);
            dig_sel     <= dig_pol(sel_hi_d);
            frame_tick  <= tick_d;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl
//   Self-checking bench for sevenseg_scan_ctrl (4 digits, dwell 4, blank 2).
//   The reference model derives the expected pins from elapsed cycles since
//   scan start using frame/slot arithmetic, plus a copy of the register file.
module tb_sevenseg_scan_ctrl;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int B  = 2;
    localparam int P  = D + B;
    localparam int FR = N * P;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         wr_en = 1'b0;
    logic [2:0]   wr_addr = 3'd0;
    logic [3:0]   wr_data = 4'h0;
    logic         wr_dp = 1'b0;
    logic [N-1:0] blank_mask = '0;
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] dig_sel;
    logic         frame_tick;

    int vectors = 0;
    int errors  = 0;

    sevenseg_scan_ctrl #(
        .NUM_DIGITS     (N),
        .DWELL_CYCLES   (D),
        .BLANK_CYCLES   (B),
        .SEG_ACTIVE_LOW (1'b0),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .blank_mask (blank_mask),
        .seg        (seg),
        .dp         (dp),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0]   seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0]   m_regs [N];
    logic         m_dps  [N];
    bit           m_run = 1'b0;
    int           m_t = 0;
    logic [3:0]   m_val = 4'h0;
    logic         m_dpv = 1'b0;
    logic         m_mask = 1'b0;
    int           cur_slot = -1;
    int           cur_within = -1;
    logic [6:0]   exp_seg = 7'h00;
    logic         exp_dp = 1'b0;
    logic [N-1:0] exp_dig = '1;
    logic         exp_tick = 1'b0;

    // Predict the effect of the coming clock edge, then advance to just after it.
    task automatic cyc();
        int  pos;
        bit  lit;
        if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
        end else begin
            m_t++;
        end
        lit      = 1'b0;
        exp_tick = 1'b0;
        if (m_run) begin
            pos        = m_t % FR;
            cur_slot   = pos / P;
            cur_within = pos % P;
            if (cur_within == 0) begin
                m_val  = m_regs[cur_slot];
                m_dpv  = m_dps[cur_slot];
                m_mask = blank_mask[cur_slot];
            end
            lit      = (cur_within < D) && !m_mask;
            exp_tick = (m_t > 0) && (pos == 0);
        end else begin
            cur_slot   = -1;
            cur_within = -1;
        end
        exp_seg = lit ? seg_ref[m_val] : 7'h00;
        exp_dp  = lit ? m_dpv : 1'b0;
        exp_dig = '1;
        if (lit) exp_dig[cur_slot] = 1'b0;
        if (wr_en && int'(wr_addr) < N) begin
            m_regs[int'(wr_addr)] = wr_data;
            m_dps[int'(wr_addr)]  = wr_dp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        #12;
        vectors++;
        if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got seg=%h dp=%b dig=%h tick=%b want seg=00 dp=0 dig=f tick=0",
                     seg, dp, dig_sel, frame_tick);
        end
        for (int i = 0; i < N; i++) begin
            m_regs[i] = 4'h0;
            m_dps[i]  = 1'b0;
        end
        m_run = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
            errors++;
            $display("FAIL reset_idle got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                     seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
        end
    endtask

    task automatic test_first_frame();
        logic [N-1:0] want_dig;
        logic [6:0]   want_seg;
        enable = 1'b1;
        vectors++;
        if (seg !== 7'h00 || dig_sel !== 4'hF) begin
            errors++;
            $display("FAIL pre_entry got seg=%h dig=%h want seg=00 dig=f", seg, dig_sel);
        end
        for (int k = 0; k < 7; k++) begin
            cyc();
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL first_frame_model t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
            if (k < 4)       begin want_dig = 4'hE; want_seg = 7'h3F; end
            else if (k < 6)  begin want_dig = 4'hF; want_seg = 7'h00; end
            else             begin want_dig = 4'hD; want_seg = 7'h3F; end
            vectors++;
            if (dig_sel !== want_dig || seg !== want_seg) begin
                errors++;
                $display("FAIL first_frame_seq k=%0d got dig=%h seg=%h want dig=%h seg=%h",
                         k, dig_sel, seg, want_dig, want_seg);
            end
        end
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_frame();
        logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h3, 4'hA};
        logic [6:0] want [4] = '{7'h06, 7'h5B, 7'h4F, 7'h77};
        int ticks = 0;
        int last  = -1;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = vals[i];
            wr_dp   = (i == 2);
            cyc();
        end
        wr_en = 1'b0;
        wr_dp = 1'b0;
        enable = 1'b1;
        for (int k = 0; k <= 2 * FR; k++) begin
            cyc();
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL frame_model t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
            if (cur_within == 0) begin
                vectors++;
                if (seg !== want[cur_slot] || dp !== (cur_slot == 2)) begin
                    errors++;
                    $display("FAIL frame_slot slot=%0d got seg=%h dp=%b want seg=%h dp=%b",
                             cur_slot, seg, dp, want[cur_slot], (cur_slot == 2));
                end
            end
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (k - last != FR) begin
                        errors++;
                        $display("FAIL frame_period got %0d want %0d", k - last, FR);
                    end
                end
                last = k;
                ticks++;
            end
        end
        vectors++;
        if (ticks != 2) begin
            errors++;
            $display("FAIL frame_tick_count got %0d want 2", ticks);
        end
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_midwrite();
        enable = 1'b1;
        for (int k = 0; k < 2 * FR; k++) begin
            cyc();
            wr_en = 1'b0;
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL midwrite_model t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
            if (k >= 7 && k <= 9) begin
                vectors++;
                if (seg !== 7'h5B) begin
                    errors++;
                    $display("FAIL midwrite_hold t=%0d got seg=%h want seg=5b", k, seg);
                end
            end
            if (k == FR + 6) begin
                vectors++;
                if (seg !== 7'h7F || dig_sel !== 4'hD) begin
                    errors++;
                    $display("FAIL midwrite_next got seg=%h dig=%h want seg=7f dig=d", seg, dig_sel);
                end
            end
            if (k == 7) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'h8; wr_dp = 1'b0;
            end
            if (k == 12) begin
                wr_en = 1'b1; wr_addr = 3'd5; wr_data = 4'hF; wr_dp = 1'b1;
            end
        end
        wr_en = 1'b0;
        wr_dp = 1'b0;
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_blank_mask();
        int last = -1;
        blank_mask = 4'b0010;
        enable = 1'b1;
        for (int k = 0; k <= 2 * FR; k++) begin
            cyc();
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL mask_model t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
            if (cur_slot == 1) begin
                vectors++;
                if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 4'hF) begin
                    errors++;
                    $display("FAIL mask_slot t=%0d got seg=%h dp=%b dig=%h want seg=00 dp=0 dig=f",
                             k, seg, dp, dig_sel);
                end
            end
            if (frame_tick === 1'b1) begin
                if (last >= 0) begin
                    vectors++;
                    if (k - last != FR) begin
                        errors++;
                        $display("FAIL mask_period got %0d want %0d", k - last, FR);
                    end
                end
                last = k;
            end
        end
        blank_mask = '0;
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_enable_drop();
        enable = 1'b1;
        for (int k = 0; k < 14; k++) begin
            cyc();
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL drop_model t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
        end
        enable = 1'b0;
        cyc();
        vectors++;
        if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL drop_off got seg=%h dp=%b dig=%h tick=%b want seg=00 dp=0 dig=f tick=0",
                     seg, dp, dig_sel, frame_tick);
        end
        cyc();
        cyc();
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            vectors++;
            if (k < 4 ? (dig_sel !== 4'hE || seg !== 7'h06) : (dig_sel !== 4'hF || seg !== 7'h00)) begin
                errors++;
                $display("FAIL reenable k=%0d got dig=%h seg=%h want dig=%h seg=%h",
                         k, dig_sel, seg, (k < 4) ? 4'hE : 4'hF, (k < 4) ? 7'h06 : 7'h00);
            end
        end
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        enable = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cyc();
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL areset_model t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (seg !== 7'h00 || dp !== 1'b0 || dig_sel !== 4'hF || frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate got seg=%h dp=%b dig=%h tick=%b want seg=00 dp=0 dig=f tick=0",
                     seg, dp, dig_sel, frame_tick);
        end
        for (int i = 0; i < N; i++) begin
            m_regs[i] = 4'h0;
            m_dps[i]  = 1'b0;
        end
        m_run  = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc();
        vectors++;
        if (seg !== 7'h3F || dig_sel !== 4'hE || dp !== 1'b0) begin
            errors++;
            $display("FAIL areset_cleared got seg=%h dig=%h dp=%b want seg=3f dig=e dp=0", seg, dig_sel, dp);
        end
        enable = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        enable = 1'b1;
        for (int k = 0; k < 400; k++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            wr_dp   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) blank_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            cyc();
            vectors++;
            if (seg !== exp_seg || dp !== exp_dp || dig_sel !== exp_dig || frame_tick !== exp_tick) begin
                errors++;
                $display("FAIL random t=%0d got seg=%h dp=%b dig=%h tick=%b want seg=%h dp=%b dig=%h tick=%b",
                         m_t, seg, dp, dig_sel, frame_tick, exp_seg, exp_dp, exp_dig, exp_tick);
            end
        end
        wr_en = 1'b0;
        enable = 1'b0;
        blank_mask = '0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_frame();
        test_midwrite();
        test_blank_mask();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode/cathode seven-segment display on the Vaman board.
- Holds one 4-bit hex value plus a decimal point per digit in an internal register file.
- Sequences digit enables one at a time, with a fixed dwell and an anti-ghosting blank gap, and drives the segment lines a..g and dp.
- Sits between user logic (the writer) and the board pins; runs off Sys_Clk0.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
DWELL_CYCLES, 20000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 200, clk cycles all digits are off between digits (0 = no gap)
SEG_ACTIVE_LOW, 0, 1 = seg/dp pins are driven low to light
DIG_ACTIVE_LOW, 1, 1 = dig_sel pins are driven low to enable

Ports:
clk  in  1  system clock (Sys_Clk0)
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning, 0 = display dark
wr_en  in  1  write strobe, single cycle, no back-pressure
wr_addr  in  3  digit index; values >= NUM_DIGITS are ignored
wr_data  in  4  hex value for the digit
wr_dp  in  1  decimal point for the digit
blank_mask  in  NUM_DIGITS  bit i = 1 suppresses digit i (its slot is still consumed)
seg  out  7  segments, bit0=a .. bit6=g, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
dig_sel  out  NUM_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async assert, sync-safe release): all digit regs = 0, all dp regs = 0, FSM = IDLE, idx = 0, counters = 0.
- Outputs at reset are at their "off" level: seg/dp inactive, dig_sel all inactive, frame_tick = 0.
- All outputs are registered; "off" and "on" always mean after polarity is applied.

FSM states: IDLE, SHOW, BLANK.
- IDLE: outputs off. When enable = 1 on a clk edge, the FSM enters SHOW with idx = 0.
- SHOW:
  - On the entry edge, the controller latches digit[idx] and dp[idx] into the display register.
  - seg = decode(value), dp driven, dig_sel bit idx active. These update on that same edge.
  - SHOW lasts exactly DWELL_CYCLES cycles.
  - If blank_mask[idx] = 1 (sampled at entry), seg, dp and dig_sel all stay off for the slot.
- BLANK: all outputs off for exactly BLANK_CYCLES cycles. Then idx advances (wraps NUM_DIGITS-1 -> 0) and the FSM re-enters SHOW.
  - If BLANK_CYCLES = 0, BLANK is skipped: SHOW(idx) goes directly to SHOW(idx+1).
- Frame period = NUM_DIGITS * (DWELL_CYCLES + BLANK_CYCLES) cycles.
- frame_tick: high for exactly one cycle, coincident with the edge that wraps idx from NUM_DIGITS-1 back to 0.
- Writes:
  - wr_en = 1 with a valid wr_addr updates digit/dp regs at that edge. The write is independent of FSM state, including IDLE.
  - An invalid wr_addr is a no-op.
- Write to the currently lit digit: the display does not change mid-dwell. The new value appears at that digit's next SHOW entry.
- Write on the exact SHOW-entry edge of the same digit: the old value is shown (the latch reads pre-write contents).
- enable deasserted in any state: FSM goes to IDLE on the next edge, outputs go off on that edge, idx and counters clear. Re-enabling restarts at digit 0 with a full dwell.
- Decode (active-high, gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Counter width = clog2(max(DWELL_CYCLES, BLANK_CYCLES)+1). No wrap beyond the terminal count.

Decomposition:
- Package sevenseg_pkg:
  - 16-entry segment pattern constant table.
  - FSM state enum (IDLE/SHOW/BLANK).
  - SEG_OFF constant.
- Sub-module sevenseg_hex_decode: combinational, 4-bit in, 7-bit active-high out. Polarity is applied in the top level.

Test Plan:
(All scenarios use NUM_DIGITS=4, DWELL_CYCLES=4, BLANK_CYCLES=2, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1.)
- Reset, then enable=1 -> seg=00, dig_sel=F until entry. Then dig_sel=E, seg=3F for 4 cycles, then dig_sel=F, seg=00 for 2 cycles, then dig_sel=D.
- Write 1,2,3,A to digits 0..3 with dp on digit 2, run 2 frames -> per-slot seg = 06, 5B, 4F, 77. dp=1 only in slot 2. frame_tick pulses every 24 cycles.
- Write 8 to digit 1 in the 2nd cycle of its SHOW -> seg stays 5B for that slot; 7F appears next frame. Write with wr_addr=5 -> no register changes.
- blank_mask=0010 -> slot 1 keeps all outputs off for 6 cycles; the other slots are unaffected; frame period remains 24.
- Drop enable mid-SHOW of digit 2 -> outputs off next edge. Re-enable -> restarts at digit 0 with a full 4-cycle dwell.
- Assert rst_n=0 asynchronously mid-frame -> outputs off immediately (no clk edge needed). After release and enable, digit 0 shows 3F (register file cleared).
